// File: rtl/wave_lut_pkg.sv
// Shared definitions for the double-buffered waveform LUT: loader states and byte width.
package wave_lut_pkg;

  localparam int LD_BYTE_W = 8;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_HI   = 2'd1,
    LD_LO   = 2'd2
  } ld_state_t;

endpackage

// File: rtl/lut_bank_mr.sv
// One waveform bank: a single synchronous write port and NCH registered read ports.
module lut_bank_mr #(
  parameter int WW = 12,
  parameter int DEPTH = 64,
  parameter int NCH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [WW-1:0]     wd,
  input  logic [NCH-1:0]    re,
  input  logic [NCH*AW-1:0] raddr,
  output logic [NCH*WW-1:0] rdata
);

  logic [WW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    for (int i = 0; i < NCH; i++) begin
      if (re[i]) rdata[i*WW +: WW] <= mem[raddr[i*AW +: AW]];
    end
  end

endmodule

// File: rtl/wave_lut_db.sv
// Double-buffered multi-channel waveform LUT: byte-serial loader into the shadow bank,
// frame-safe bank swap, and a two-stage read pipeline with optional quarter-wave folding.
module wave_lut_db
  import wave_lut_pkg::*;
#(
  parameter int WW = 12,
  parameter int DEPTH = 64,
  parameter int NCH = 2,
  parameter int AW = $clog2(DEPTH),
  parameter int PW = AW + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld_valid,
  input  logic [LD_BYTE_W-1:0] ld_data,
  input  logic                 ld_last,
  output logic                 ld_ready,
  input  logic                 swap_req,
  output logic                 swap_done,
  input  logic                 quarter,
  input  logic [NCH-1:0]       re,
  input  logic [NCH*PW-1:0]    ra,
  output logic [NCH*WW-1:0]    rd,
  output logic [NCH-1:0]       rd_valid
);

  ld_state_t            state;
  logic [AW-1:0]        ptr;
  logic [LD_BYTE_W-1:0] hi_byte;
  logic                 act;
  logic                 pend;
  logic                 swap_go;
  logic                 accept;
  logic                 wr_en;
  logic [1:0]           we_b;
  logic [WW-1:0]        wd;

  logic [NCH*AW-1:0]    idx_p0;
  logic [NCH-1:0]       inv_p0;
  logic [NCH-1:0]       vld_p1;
  logic [NCH-1:0]       inv_p1;
  logic [NCH-1:0]       sel_p1;
  logic [NCH*WW-1:0]    rdata_b0;
  logic [NCH*WW-1:0]    rdata_b1;
  logic [NCH-1:0]       vld_p2;

  function automatic logic [WW-1:0] mirror_word(input logic [WW-1:0] w, input logic flip);
    return flip ? ~w : w;
  endfunction

  // The exchange stalls the loader for its cycle, so it can only land between frames.
  assign swap_go  = pend && (state == LD_IDLE);
  assign ld_ready = !swap_go;
  assign accept   = ld_valid && ld_ready;
  assign wr_en    = accept && (state == LD_LO) && !rst;
  assign we_b[0]  = wr_en && act;
  assign we_b[1]  = wr_en && !act;
  assign wd       = WW'({hi_byte, ld_data});

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LD_IDLE;
      pend      <= 1'b0;
      act       <= 1'b0;
      swap_done <= 1'b0;
    end else begin
      swap_done <= swap_go;
      if (swap_go) begin
        act  <= !act;
        pend <= 1'b0;
      end else if (swap_req) begin
        pend <= 1'b1;
      end
      if (accept) begin
        case (state)
          LD_IDLE: state <= ld_last ? LD_IDLE : LD_HI;
          LD_HI:   state <= ld_last ? LD_IDLE : LD_LO;
          LD_LO:   state <= ld_last ? LD_IDLE : LD_HI;
          default: state <= LD_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      case (state)
        LD_IDLE: ptr     <= ld_data[AW-1:0];
        LD_HI:   hi_byte <= ld_data;
        LD_LO:   ptr     <= ptr + 1'b1;
        default: ;
      endcase
    end
  end

  // Stage 0: fold the phase index; odd quadrants mirror the address, upper half inverts data.
  always_comb begin
    idx_p0 = '0;
    inv_p0 = '0;
    for (int i = 0; i < NCH; i++) begin
      idx_p0[i*AW +: AW] = (quarter && ra[i*PW+AW]) ? ~ra[i*PW +: AW] : ra[i*PW +: AW];
      inv_p0[i]          = quarter && ra[i*PW+AW+1];
    end
  end

  lut_bank_mr #(.WW(WW), .DEPTH(DEPTH), .NCH(NCH)) u_bank0 (
    .clk   (clk),
    .we    (we_b[0]),
    .wa    (ptr),
    .wd    (wd),
    .re    (re),
    .raddr (idx_p0),
    .rdata (rdata_b0)
  );

  lut_bank_mr #(.WW(WW), .DEPTH(DEPTH), .NCH(NCH)) u_bank1 (
    .clk   (clk),
    .we    (we_b[1]),
    .wa    (ptr),
    .wd    (wd),
    .re    (re),
    .raddr (idx_p0),
    .rdata (rdata_b1)
  );

  // Stage 1: remember which bank was active at launch so a swap never tears an in-flight read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (re[i]) begin
        inv_p1[i] <= inv_p0[i];
        sel_p1[i] <= act;
      end
    end
  end

  // Stage 2: select bank, apply inversion, hold rd when nothing completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= '0;
      vld_p2 <= '0;
      rd     <= '0;
    end else begin
      vld_p1 <= re;
      vld_p2 <= vld_p1;
      for (int i = 0; i < NCH; i++) begin
        if (vld_p1[i]) begin
          rd[i*WW +: WW] <= mirror_word(sel_p1[i] ? rdata_b1[i*WW +: WW] : rdata_b0[i*WW +: WW],
                                        inv_p1[i]);
        end
      end
    end
  end

  assign rd_valid = vld_p2;

endmodule

// File: tb/tb_wave_lut_db.sv
// Directed bench for wave_lut_db: bank-level model with a per-cycle read scoreboard.
module tb_wave_lut_db;
  localparam int WW = 12;
  localparam int DEPTH = 64;
  localparam int NCH = 2;
  localparam int AW = 6;
  localparam int PW = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ld_valid = 1'b0;
  logic [7:0]        ld_data = '0;
  logic              ld_last = 1'b0;
  logic              ld_ready;
  logic              swap_req = 1'b0;
  logic              swap_done;
  logic              quarter = 1'b0;
  logic [NCH-1:0]    re = '0;
  logic [NCH*PW-1:0] ra = '0;
  logic [NCH*WW-1:0] rd;
  logic [NCH-1:0]    rd_valid;

  wave_lut_db #(.WW(WW), .DEPTH(DEPTH), .NCH(NCH)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .swap_req(swap_req), .swap_done(swap_done), .quarter(quarter),
    .re(re), .ra(ra), .rd(rd), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int mbank[2][DEPTH];
  int model_act = 0;
  int frame_w[DEPTH];
  int cyc = 0;
  bit due_v[NCH][4];
  int due_d[NCH][4];
  int hold[NCH];
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, got, exp);
    end
  endtask

  // Expected word for a phase index, computed from the waveform's symmetry rules.
  function automatic int lookup(input int a, input bit qm);
    int q = a / DEPTH;
    int i = a % DEPTH;
    int j = i;
    int v;
    if (qm && (q == 1 || q == 3)) j = DEPTH - 1 - i;
    v = mbank[model_act][j];
    if (qm && q >= 2) v = (1 << WW) - 1 - v;
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        hold[c] = 0;
        for (int s = 0; s < 4; s++) due_v[c][s] = 1'b0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (re[c]) begin
          due_v[c][(cyc+2)%4] = 1'b1;
          due_d[c][(cyc+2)%4] = lookup(int'(ra[c*PW +: PW]), quarter);
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < NCH; c++) begin
        bit ev;
        ev = due_v[c][cyc%4];
        if (ev) begin
          hold[c] = due_d[c][cyc%4];
          due_v[c][cyc%4] = 1'b0;
        end
        chk("stream_rd_valid", 32'(rd_valid[c]), 32'(ev));
        chk("stream_rd", 32'(rd[c*WW +: WW]), 32'(hold[c]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int w = 0;
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    while (!ld_ready && w < 20) begin
      tick();
      w++;
    end
    if (!ld_ready) chk("ld_ready_wait", 32'(ld_ready), 32'd1);
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic send_frame(input int start, input int n);
    send_byte(8'(start), 1'b0);
    for (int k = 0; k < n; k++) begin
      send_byte(8'(frame_w[k] >> 8), 1'b0);
      send_byte(8'(frame_w[k] & 255), k == n - 1);
      mbank[1-model_act][(start+k)%DEPTH] = frame_w[k];
    end
  endtask

  task automatic do_swap();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("swap_exec_ready_low", 32'(ld_ready), 32'd0);
    tick();
    model_act ^= 1;
    chk("swap_done_pulse", 32'(swap_done), 32'd1);
    chk("swap_ready_back", 32'(ld_ready), 32'd1);
    tick();
    chk("swap_done_clear", 32'(swap_done), 32'd0);
  endtask

  task automatic rd_chk(input string nm, input int ch, input int a, input bit qm, input int exp);
    re[ch] = 1'b1;
    ra[ch*PW +: PW] = 8'(a);
    quarter = qm;
    tick();
    re[ch] = 1'b0;
    quarter = 1'b0;
    tick();
    chk({nm, "_valid"}, 32'(rd_valid[ch]), 32'd1);
    chk(nm, 32'(rd[ch*WW +: WW]), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_rd", 32'(rd), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_swap_done", 32'(swap_done), 32'd0);
    chk("reset_ld_ready", 32'(ld_ready), 32'd1);

    // Fill both banks with known patterns.
    for (int k = 0; k < DEPTH; k++) frame_w[k] = (k * 37 + 5) & 12'hFFF;
    send_frame(0, DEPTH);
    do_swap();
    for (int k = 0; k < DEPTH; k++) frame_w[k] = (k * 91 + 1000) & 12'hFFF;
    send_frame(0, DEPTH);

    // Loader frame lands in shadow; active unaffected until swap.
    frame_w[0] = 12'hABC;
    frame_w[1] = 12'h123;
    send_frame(5, 2);
    rd_chk("old_active_ra5", 0, 5, 1'b0, 12'h0BE);
    do_swap();
    re = 2'b11;
    ra = {8'd6, 8'd5};
    tick();
    re = 2'b00;
    tick();
    chk("new_ra5_valid", 32'(rd_valid), 32'd3);
    chk("new_ra5", 32'(rd[0 +: WW]), 32'hABC);
    chk("new_ra6", 32'(rd[WW +: WW]), 32'h123);
    rd_chk("full_ignores_upper", 0, 8'hC5, 1'b0, 12'hABC);

    // Quarter-wave reconstruction.
    frame_w[0] = 12'h100;
    send_frame(3, 1);
    frame_w[0] = 12'h200;
    send_frame(60, 1);
    do_swap();
    rd_chk("quarter_q0", 0, 3, 1'b1, 12'h100);
    rd_chk("quarter_q1", 1, 67, 1'b1, 12'h200);
    rd_chk("quarter_q2", 0, 131, 1'b1, 12'hEFF);
    rd_chk("quarter_q3", 1, 195, 1'b1, 12'hDFF);
    for (int k = 0; k < 24; k++) begin
      re = 2'b11;
      ra = {8'((k * 53 + 7) & 255), 8'((k * 37) & 255)};
      quarter = k[0];
      tick();
    end
    re = '0;
    quarter = 1'b0;
    tick();
    tick();

    // Swap requested mid-frame waits for the frame end; repeated requests merge.
    send_byte(8'h10, 1'b0);
    swap_req = 1'b1;
    chk("mid_frame_ready_hi", 32'(ld_ready), 32'd1);
    send_byte(8'h07, 1'b0);
    chk("mid_frame_ready_lo", 32'(ld_ready), 32'd1);
    send_byte(8'h77, 1'b0);
    chk("mid_frame_ready_hi2", 32'(ld_ready), 32'd1);
    send_byte(8'h08, 1'b0);
    swap_req = 1'b0;
    chk("mid_frame_ready_lo2", 32'(ld_ready), 32'd1);
    send_byte(8'h88, 1'b1);
    mbank[1-model_act][16] = 12'h777;
    mbank[1-model_act][17] = 12'h888;
    chk("post_frame_swap_stall", 32'(ld_ready), 32'd0);
    chk("post_frame_no_done_yet", 32'(swap_done), 32'd0);
    tick();
    model_act ^= 1;
    chk("post_frame_ready", 32'(ld_ready), 32'd1);
    chk("post_frame_done", 32'(swap_done), 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("merged_no_second_done", 32'(swap_done), 32'd0);
      chk("merged_ready", 32'(ld_ready), 32'd1);
    end
    rd_chk("mid_swap_word0", 0, 16, 1'b0, 12'h777);
    rd_chk("mid_swap_word1", 1, 17, 1'b0, 12'h888);

    // Pointer wrap, aborted frame, then a clean frame.
    frame_w[0] = 12'h456;
    frame_w[1] = 12'h789;
    send_frame(63, 2);
    send_byte(8'h20, 1'b0);
    send_byte(8'h0F, 1'b1);
    frame_w[0] = 12'h111;
    send_frame(33, 1);
    do_swap();
    rd_chk("wrap_63", 0, 63, 1'b0, 12'h456);
    rd_chk("wrap_0", 1, 0, 1'b0, 12'h789);
    rd_chk("abort_no_write", 0, 32, 1'b0, 12'h4A5);
    rd_chk("after_abort", 1, 33, 1'b0, 12'h111);

    // Reset in LO with a read in flight and a pending swap.
    send_byte(8'h30, 1'b0);
    ld_valid = 1'b1;
    ld_data = 8'h0A;
    swap_req = 1'b1;
    re[0] = 1'b1;
    ra[0 +: PW] = 8'd1;
    tick();
    swap_req = 1'b0;
    re[0] = 1'b0;
    ld_data = 8'h0B;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ld_valid = 1'b0;
    model_act = 0;
    chk("rst_flush_valid", 32'(rd_valid), 32'd0);
    chk("rst_pending_cleared", 32'(ld_ready), 32'd1);
    chk("rst_no_done", 32'(swap_done), 32'd0);
    tick();
    chk("rst_pending_cleared2", 32'(ld_ready), 32'd1);
    rd_chk("rst_no_lo_write", 0, 48, 1'b0, 12'h4F8);
    frame_w[0] = 12'hCCD;
    send_frame(49, 1);
    do_swap();
    rd_chk("frame_after_rst", 1, 49, 1'b0, 12'hCCD);
    rd_chk("shadow_untouched", 0, 48, 1'b0, 12'h6F5);

    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
